bus_mux_arb: RTL and testbench

BUS_MUX_ARB -- requirements
Module: bus_mux_arb

---
 rtl/bus_mux_pkg.sv | 17 +
 rtl/bus_mux_arb_prio_enc.sv | 36 +++
 rtl/bus_mux_arb.sv | 88 ++++++++
 tb/tb_bus_mux_arb.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bus_mux_pkg.sv
// Shared defaults and helpers for the round-robin bus multiplexer.
package bus_mux_pkg;

  localparam int BUS_WIDTH_DEF = 32;
  localparam int BUS_CHAN_DEF  = 4;

  // Binary index of the set bit in a one-hot word (zero when none is set).
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_mux_arb_prio_enc.sv
// Combinational round-robin priority encoder: first requester at or after ptr wins.
module rr_prio_enc
  import bus_mux_pkg::*;
#(
  parameter int N = BUS_CHAN_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_req
);

  localparam int SW = $clog2(N);

  logic [N-1:0] w_oh;

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    w_oh  = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        w_oh[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign winner  = SW'(onehot_to_idx(32'(w_oh)));
  assign any_req = |req;

endmodule

// File: rtl/bus_mux_arb.sv
// Registered round-robin N-channel bus multiplexer/arbiter.
// Define BUS_MUX_LOCK_EN to add the mux_lock input that holds the current grant.
module bus_mux_arb
  import bus_mux_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEF,
  parameter int N     = BUS_CHAN_DEF
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [N*WIDTH-1:0]   mux_in,
  input  logic [N-1:0]         mux_req,
  input  logic                 mux_en,
`ifdef BUS_MUX_LOCK_EN
  input  logic                 mux_lock,
`endif
  output logic [WIDTH-1:0]     mux_out,
  output logic [N-1:0]         mux_grant,
  output logic [$clog2(N)-1:0] mux_sel,
  output logic                 mux_valid
);

  localparam int SW = $clog2(N);

  logic [WIDTH-1:0] r_out;
  logic [N-1:0]     r_grant;
  logic [SW-1:0]    r_sel;
  logic             r_valid;
  logic [SW-1:0]    r_ptr;

  logic [SW-1:0]    w_winner;
  logic             w_any;
  logic [N-1:0]     w_oh;
  logic [SW-1:0]    w_ptr_nxt;

  rr_prio_enc #(.N(N)) u_enc (
    .req     (mux_req),
    .ptr     (r_ptr),
    .winner  (w_winner),
    .any_req (w_any)
  );

  always_comb begin
    w_oh           = '0;
    w_oh[w_winner] = 1'b1;
  end

  assign w_ptr_nxt = (w_winner == SW'(N-1)) ? '0 : w_winner + 1'b1;

`ifdef BUS_MUX_LOCK_EN
  // Lock only bites while the held channel is still requesting.
  logic w_lock;
  assign w_lock = mux_lock & r_valid & (|(mux_req & r_grant));
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_out   <= '0;
      r_grant <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (mux_en) begin
`ifdef BUS_MUX_LOCK_EN
      if (w_lock) begin
        r_out   <= mux_in[r_sel*WIDTH +: WIDTH];
        r_valid <= 1'b1;
      end else
`endif
      if (w_any) begin
        r_out   <= mux_in[w_winner*WIDTH +: WIDTH];
        r_grant <= w_oh;
        r_sel   <= w_winner;
        r_valid <= 1'b1;
        r_ptr   <= w_ptr_nxt;
      end else begin
        r_valid <= 1'b0;
        r_grant <= '0;
      end
    end
  end

  assign mux_out   = r_out;
  assign mux_grant = r_grant;
  assign mux_sel   = r_sel;
  assign mux_valid = r_valid;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed table-driven bench for bus_mux_arb (WIDTH=32, N=4).
module tb_bus_mux_arb;

  logic         clock;
  logic         clear;
  logic [127:0] mux_in;
  logic [3:0]   mux_req;
  logic         mux_en;
`ifdef BUS_MUX_LOCK_EN
  logic         mux_lock;
`endif
  logic [31:0]  mux_out;
  logic [3:0]   mux_grant;
  logic [1:0]   mux_sel;
  logic         mux_valid;

  int n_vec;
  int n_bad;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [3:0]   req;
    logic         en;
    logic [1:0]   sel;
    logic [3:0]   grant;
    logic [31:0]  out;
    logic         valid;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] D = {32'd240, 32'd15, 32'd170, 32'd85};
  localparam logic [127:0] G = {32'hDEAD_BEEF, 32'd15, 32'h1234_5678, 32'hCAFE_F00D};

  bus_mux_arb #(.WIDTH(32), .N(4)) dut (
    .clock     (clock),
    .clear     (clear),
    .mux_in    (mux_in),
    .mux_req   (mux_req),
    .mux_en    (mux_en),
`ifdef BUS_MUX_LOCK_EN
    .mux_lock  (mux_lock),
`endif
    .mux_out   (mux_out),
    .mux_grant (mux_grant),
    .mux_sel   (mux_sel),
    .mux_valid (mux_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input string nm, input logic [127:0] din, input logic [3:0] req,
                     input logic en, input logic [1:0] sel, input logic [3:0] grant,
                     input logic [31:0] out, input logic valid);
    vec_t v;
    v.name = nm; v.din = din; v.req = req; v.en = en;
    v.sel = sel; v.grant = grant; v.out = out; v.valid = valid;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [1:0] sel, input logic [3:0] grant,
                       input logic [31:0] out, input logic valid);
    n_vec++;
    if ({mux_sel, mux_grant, mux_out, mux_valid} !== {sel, grant, out, valid}) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d grant=%b out=%0h valid=%b, want sel=%0d grant=%b out=%0h valid=%b",
               nm, mux_sel, mux_grant, mux_out, mux_valid, sel, grant, out, valid);
    end
  endtask

  task automatic step(input logic [127:0] din, input logic [3:0] req, input logic en);
    mux_in  = din;
    mux_req = req;
    mux_en  = en;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    //   name         din req    en sel grant    out            valid
    add("rot0",       D, 4'hF,  1, 0, 4'b0001, 32'd85,        1);
    add("rot1",       D, 4'hF,  1, 1, 4'b0010, 32'd170,       1);
    add("rot2",       D, 4'hF,  1, 2, 4'b0100, 32'd15,        1);
    add("rot3",       D, 4'hF,  1, 3, 4'b1000, 32'd240,       1);
    add("rot_wrap",   D, 4'hF,  1, 0, 4'b0001, 32'd85,        1);
    add("rot5",       D, 4'hF,  1, 1, 4'b0010, 32'd170,       1);
    add("rot6",       D, 4'hF,  1, 2, 4'b0100, 32'd15,        1);
    add("idle",       D, 4'h0,  1, 2, 4'b0000, 32'd15,        0);
    add("idle_wrap",  D, 4'h5,  1, 0, 4'b0001, 32'd85,        1);
    add("en_off0",    D, 4'hF,  0, 0, 4'b0001, 32'd85,        1);
    add("en_off1",    D, 4'h0,  0, 0, 4'b0001, 32'd85,        1);
    add("en_off2",    D, 4'h8,  0, 0, 4'b0001, 32'd85,        1);
    add("en_resume",  D, 4'hF,  1, 1, 4'b0010, 32'd170,       1);
    add("alt0",       D, 4'h3,  1, 0, 4'b0001, 32'd85,        1);
    add("alt1",       D, 4'h3,  1, 1, 4'b0010, 32'd170,       1);
    add("alt2",       D, 4'h3,  1, 0, 4'b0001, 32'd85,        1);
    add("alt3",       D, 4'h3,  1, 1, 4'b0010, 32'd170,       1);
    add("single0",    G, 4'h4,  1, 2, 4'b0100, 32'd15,        1);
    add("single1",    G, 4'h4,  1, 2, 4'b0100, 32'd15,        1);
    add("chan3_data", G, 4'h8,  1, 3, 4'b1000, 32'hDEAD_BEEF, 1);
    add("en_off_hold",D, 4'h0,  0, 3, 4'b1000, 32'hDEAD_BEEF, 1);

    clear   = 1'b1;
    mux_in  = D;
    mux_req = 4'h0;
    mux_en  = 1'b0;
`ifdef BUS_MUX_LOCK_EN
    mux_lock = 1'b0;
`endif
    #1;
    check("reset", 2'd0, 4'b0000, 32'd0, 1'b0);
    #12;
    clear = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].din, vecs[i].req, vecs[i].en);
      check(vecs[i].name, vecs[i].sel, vecs[i].grant, vecs[i].out, vecs[i].valid);
    end

    // Mid-stream clear: outputs must drop without a clock edge and stay low across edges.
    step(D, 4'hF, 1'b1);
    check("pre_clear", 2'd0, 4'b0001, 32'd85, 1'b1);
    #2;
    clear = 1'b1;
    #1;
    check("clear_async", 2'd0, 4'b0000, 32'd0, 1'b0);
    step(D, 4'hF, 1'b1);
    check("clear_held", 2'd0, 4'b0000, 32'd0, 1'b0);
    clear = 1'b0;
    step(D, 4'b1010, 1'b1);
    check("post_clear", 2'd1, 4'b0010, 32'd170, 1'b1);

`ifdef BUS_MUX_LOCK_EN
    // ptr is now 2; grant channel 0, then lock it while channel 1 also requests.
    step(D, 4'b0001, 1'b1);
    check("lock_seed", 2'd0, 4'b0001, 32'd85, 1'b1);
    mux_lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(D, 4'b0011, 1'b1);
      check("lock_hold", 2'd0, 4'b0001, 32'd85, 1'b1);
    end
    step(D, 4'b0010, 1'b1);
    check("lock_release", 2'd1, 4'b0010, 32'd170, 1'b1);
    mux_lock = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
